matrix_bus_packer: RTL and testbench

//  Operand-side front end of the matrix math engine. Accepts matrix elements one at a time over a

---
 rtl/matrix_bus_packer_if.sv | 31 +++
 rtl/matrix_bus_packer.sv | 121 ++++++++++++
 tb/tb_matrix_bus_packer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_bus_packer_if.sv
// Element-stream and packed-bus signals of the matrix operand packer.
// slave: packer side. master: element source plus multiplier side.
interface matrix_bus_packer_if #(
  parameter int DIM    = 4,
  parameter int ELEM_W = 16
);
  localparam int BUS_W = DIM * DIM * ELEM_W;
  localparam int CNT_W = $clog2(DIM * DIM) + 1;

  // Both streams transfer on a rising edge where valid && ready are high.
  // valid must not depend on ready, and data is held while valid waits for ready.
  logic [ELEM_W-1:0] elem_in;
  logic              elem_valid;
  logic              elem_ready;
  logic [BUS_W-1:0]  bus_out;
  logic              bus_valid;
  logic              bus_ready;
  logic              bus_is_b;
  logic              pair_done;
  logic [CNT_W-1:0]  elem_count;

  modport slave (
    input  elem_in, elem_valid, bus_ready,
    output elem_ready, bus_out, bus_valid, bus_is_b, pair_done, elem_count
  );

  modport master (
    output elem_in, elem_valid, bus_ready,
    input  elem_ready, bus_out, bus_valid, bus_is_b, pair_done, elem_count
  );
endinterface

// File: rtl/matrix_bus_packer.sv
// Packs DIM*DIM streamed elements into one bus word and presents operand A, then B.
// Define TRANSPOSE_EN to accept column-major input while keeping row-major packing.
module matrix_bus_packer #(
  parameter int DIM    = 4,
  parameter int ELEM_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  matrix_bus_packer_if.slave  io,
  output logic                dbg_state
);
  localparam int BUS_W = DIM * DIM * ELEM_W;
  localparam int CNT_W = $clog2(DIM * DIM) + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIM * DIM - 1);
  localparam logic [CNT_W-1:0] DIM_C = CNT_W'(DIM);

  typedef enum logic {
    FILL = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [BUS_W-1:0]   bus_q, bus_d;
  logic               is_b_q, is_b_d;
  logic               pair_done_q, pair_done_d;
  logic [CNT_W-1:0]   slot;
  logic               elem_acc;
  logic               bus_acc;
  logic               elem_ready;
  logic               bus_valid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  // Next-state logic; clr wins over both handshakes
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = FILL;
    end else begin
      case (state_q)
        FILL:    if (elem_acc && count_q == LAST) state_d = SEND;
        SEND:    if (bus_acc) state_d = FILL;
        default: state_d = FILL;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    elem_ready = 1'b0;
    bus_valid  = 1'b0;
    case (state_q)
      FILL:    elem_ready = 1'b1;
      SEND:    bus_valid  = 1'b1;
      default: elem_ready = 1'b0;
    endcase
  end

  assign elem_acc = io.elem_valid && elem_ready && !clr;
  assign bus_acc  = bus_valid && io.bus_ready && !clr;

`ifdef TRANSPOSE_EN
  // Column-major arrival: element k is (row = k%DIM, col = k/DIM).
  always_comb begin
    slot = (count_q % DIM_C) * DIM_C + (count_q / DIM_C);
  end
`else
  always_comb begin
    slot = count_q;
  end
`endif

  always_comb begin
    count_d     = count_q;
    bus_d       = bus_q;
    is_b_d      = is_b_q;
    pair_done_d = 1'b0;
    if (clr) begin
      count_d = '0;
      is_b_d  = 1'b0;
    end else begin
      if (elem_acc) begin
        bus_d[slot*ELEM_W +: ELEM_W] = io.elem_in;
        count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
      end
      if (bus_acc) begin
        is_b_d      = !is_b_q;
        pair_done_d = is_b_q;
      end
    end
  end

  // bus_q is not cleared between matrices: every slot is rewritten before SEND.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      bus_q       <= '0;
      is_b_q      <= 1'b0;
      pair_done_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      bus_q       <= bus_d;
      is_b_q      <= is_b_d;
      pair_done_q <= pair_done_d;
    end
  end

  assign io.elem_ready = elem_ready;
  assign io.bus_valid  = bus_valid;
  assign io.bus_out    = bus_q;
  assign io.bus_is_b   = is_b_q;
  assign io.pair_done  = pair_done_q;
  assign io.elem_count = count_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_matrix_bus_packer.sv
// Scoreboard bench for matrix_bus_packer: streams matrices, checks packed words,
// operand tagging, stalls, pair_done pulses, clr aborts and mid-fill reset.
module tb_matrix_bus_packer;
  localparam int DIM    = 4;
  localparam int ELEM_W = 16;
  localparam int N      = DIM * DIM;
  localparam int BUS_W  = N * ELEM_W;

  logic clk;
  logic rst;
  logic clr;
  logic dbg_state;

  matrix_bus_packer_if #(.DIM(DIM), .ELEM_W(ELEM_W)) io ();

  matrix_bus_packer #(.DIM(DIM), .ELEM_W(ELEM_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .io        (io),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [BUS_W:0] exp_q[$];
  logic           model_is_b;
  logic           exp_pair;

  logic [ELEM_W-1:0] mat_a [N] = '{5, 8, 9, 2, 7, 3, 8, 4, 6, 5, 4, 3, 8, 5, 7, 6};
  logic [ELEM_W-1:0] mat_b [N] = '{11, 14, 19, 18, 6, 9, 3, 5, 12, 10, 15, 14, 1, 3, 5, 7};
  logic [ELEM_W-1:0] mat_r [N];

  task automatic check_eq(input string tag, input logic [BUS_W-1:0] act,
                          input logic [BUS_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [BUS_W-1:0] pack(input logic [ELEM_W-1:0] m [N]);
    logic [BUS_W-1:0] p;
    p = '0;
    for (int k = 0; k < N; k++) p[k*ELEM_W +: ELEM_W] = m[k];
    return p;
  endfunction

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_elem(input logic [ELEM_W-1:0] v);
    logic ok;
    io.elem_in    = v;
    io.elem_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      ok = io.elem_ready;
      step();
      if (ok) break;
    end
    if (!ok) check_eq("elem_timeout", ok, 1'b1);
  endtask

  // Streams the first cnt elements of matrix m in wire order; a full matrix is scoreboarded.
  task automatic send_matrix(input logic [ELEM_W-1:0] m [N], input int cnt);
    int idx;
    for (int k = 0; k < cnt; k++) begin
      check_eq("early_valid", io.bus_valid, 1'b0);
`ifdef TRANSPOSE_EN
      idx = (k % DIM) * DIM + k / DIM;
`else
      idx = k;
`endif
      drive_elem(m[idx]);
    end
    io.elem_valid = 1'b0;
    if (cnt == N) begin
      exp_q.push_back({model_is_b, pack(m)});
      model_is_b = ~model_is_b;
    end
  endtask

  task automatic wait_accept();
    for (int n = 0; n < 64; n++) begin
      if (!io.bus_valid) break;
      step();
    end
    check_eq("accept_timeout", io.bus_valid, 1'b0);
  endtask

  // Scoreboard: pops one expected word per bus handshake, checks pair_done one cycle later.
  always @(negedge clk) begin
    logic [BUS_W:0] e;
    if (!rst) check_eq("pair_done", io.pair_done, exp_pair);
    exp_pair = 1'b0;
    if (!rst && !clr && io.bus_valid && io.bus_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_bus", io.bus_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check_eq("bus_out", io.bus_out, e[BUS_W-1:0]);
        check_eq("bus_is_b", io.bus_is_b, e[BUS_W]);
        exp_pair = e[BUS_W];
      end
    end
  end

  initial begin
    logic [BUS_W-1:0] bo;
    exp_pair      = 1'b0;
    model_is_b    = 1'b0;
    rst           = 1'b1;
    clr           = 1'b0;
    io.elem_in    = '0;
    io.elem_valid = 1'b0;
    io.bus_ready  = 1'b0;
    repeat (2) step();

    // Reset values
    check_eq("rst_elem_ready", io.elem_ready, 1'b1);
    check_eq("rst_bus_valid", io.bus_valid, 1'b0);
    check_eq("rst_bus_is_b", io.bus_is_b, 1'b0);
    check_eq("rst_pair_done", io.pair_done, 1'b0);
    check_eq("rst_elem_count", io.elem_count, 0);
    check_eq("rst_bus_out", io.bus_out, 0);
    check_eq("rst_state", dbg_state, 1'b0);
    rst = 1'b0;
    step();

    // Operand A, back-to-back with bus_ready high
    io.bus_ready = 1'b1;
    send_matrix(mat_a, N);
    bo = io.bus_out;
    check_eq("a_latency_valid", io.bus_valid, 1'b1);
    check_eq("a_elem_ready", io.elem_ready, 1'b0);
    check_eq("a_count_wrap", io.elem_count, 0);
    check_eq("a_slot0", bo[15:0], 16'd5);
    check_eq("a_slot1", bo[31:16], 16'd8);
    check_eq("a_slot3", bo[63:48], 16'd2);
    check_eq("a_slot15", bo[255:240], 16'd6);
    check_eq("a_is_b", io.bus_is_b, 1'b0);
    wait_accept();
    check_eq("a_is_b_after", io.bus_is_b, 1'b1);

    // Operand B with a 5-cycle stall; elem_valid held high must not be absorbed
    io.bus_ready = 1'b0;
    send_matrix(mat_b, N);
    io.elem_valid = 1'b1;
    io.elem_in    = 16'hdead;
    for (int c = 0; c < 5; c++) begin
      bo = io.bus_out;
      check_eq("stall_valid", io.bus_valid, 1'b1);
      check_eq("stall_elem_ready", io.elem_ready, 1'b0);
      check_eq("stall_bus_out", bo, pack(mat_b));
      check_eq("stall_count", io.elem_count, 0);
      step();
    end
    check_eq("b_slot0", bo[15:0], 16'd11);
    check_eq("b_slot15", bo[255:240], 16'd7);
    io.elem_valid = 1'b0;
    io.bus_ready  = 1'b1;
    step();
    check_eq("b_is_b_after", io.bus_is_b, 1'b0);
    check_eq("b_state_after", dbg_state, 1'b0);
    step();

    // Abort after 9 elements, then a clean operand A
    send_matrix(mat_a, 9);
    check_eq("abort_count9", io.elem_count, 9);
    clr = 1'b1;
    step();
    clr = 1'b0;
    model_is_b = 1'b0;
    check_eq("clr_count", io.elem_count, 0);
    check_eq("clr_valid", io.bus_valid, 1'b0);
    check_eq("clr_is_b", io.bus_is_b, 1'b0);
    send_matrix(mat_a, N);
    check_eq("abort_a_valid", io.bus_valid, 1'b1);
    check_eq("abort_a_out", io.bus_out, pack(mat_a));
    wait_accept();

    // clr colliding with the operand B handshake
    io.bus_ready = 1'b0;
    send_matrix(mat_b, N);
    check_eq("coll_valid", io.bus_valid, 1'b1);
    clr          = 1'b1;
    io.bus_ready = 1'b1;
    step();
    clr          = 1'b0;
    io.bus_ready = 1'b0;
    void'(exp_q.pop_front());
    model_is_b = 1'b0;
    check_eq("coll_pair_done", io.pair_done, 1'b0);
    check_eq("coll_state", dbg_state, 1'b0);
    check_eq("coll_is_b", io.bus_is_b, 1'b0);
    check_eq("coll_valid_low", io.bus_valid, 1'b0);
    step();

    // Reset in the middle of a fill
    send_matrix(mat_b, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_is_b = 1'b0;
    check_eq("midrst_count", io.elem_count, 0);
    check_eq("midrst_bus_out", io.bus_out, 0);
    check_eq("midrst_ready", io.elem_ready, 1'b1);

    // Random pair at full throughput
    io.bus_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < N; k++) mat_r[k] = ELEM_W'($urandom_range(0, 65535));
      send_matrix(mat_r, N);
      check_eq("rnd_valid", io.bus_valid, 1'b1);
      wait_accept();
    end
    repeat (3) step();
    check_eq("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
